// File: rtl/ranger_pkg.sv
// Shared definitions for the ultrasonic ranger: FSM state encoding,
// the sound round-trip constant and the "no echo" distance code.
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    // Echo round-trip time for one centimetre of range.
    localparam int US_PER_CM = 58;

    // Distance reported when no valid echo was measured.
    localparam logic [15:0] NO_ECHO = 16'hFFFF;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick generator: one-cycle pulse every CLK_FREQ_HZ/1e6 clocks.
module us_tick_gen
    import ranger_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 24_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // Clock rates below 1 MHz degenerate to a tick on every cycle.
    localparam int DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
    localparam int W   = cnt_width(DIV - 1);
    localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);

    logic [W-1:0] div_reg;

    // Free-running divider that wraps after DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range finder controller: fires a trigger pulse every period,
// times the returned echo pulse and reports the range in centimetres.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 24_000_000,
    parameter int TRIG_US     = 10,
    parameter int PERIOD_MS   = 60,
    parameter int TIMEOUT_US  = 30_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] distance,
    output logic        valid,
    output logic        timeout
);

    localparam int PERIOD_TICKS = PERIOD_MS * 1000;
    localparam int PW  = cnt_width(PERIOD_TICKS);
    localparam int TW  = cnt_width(TRIG_US - 1);
    localparam int OW  = cnt_width(TIMEOUT_US - 1);
    localparam int PSW = cnt_width(US_PER_CM - 1);

    localparam logic [PW-1:0]  PERIOD_FULL = PW'(PERIOD_TICKS);
    localparam logic [PW-1:0]  PERIOD_PRE  = PW'(PERIOD_TICKS - 1);
    localparam logic [TW-1:0]  TRIG_LAST   = TW'(TRIG_US - 1);
    localparam logic [OW-1:0]  TMO_LAST    = OW'(TIMEOUT_US - 1);
    localparam logic [PSW-1:0] PS_LAST     = PSW'(US_PER_CM - 1);

    logic tick;

    logic echo_meta_reg, echo_sync_reg, echo_prev_reg;
    logic echo_rise, echo_fall;

    state_t          state_reg;
    logic [PW-1:0]   period_reg;
    logic [TW-1:0]   trig_cnt_reg;
    logic [OW-1:0]   tmo_cnt_reg;
    logic [PSW-1:0]  cm_pre_reg, cm_pre_next;
    logic [15:0]     cm_count_reg, cm_count_next;
    logic            period_hit;

    us_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer for echo plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta_reg <= 1'b0;
            echo_sync_reg <= 1'b0;
            echo_prev_reg <= 1'b0;
        end else begin
            echo_meta_reg <= echo;
            echo_sync_reg <= echo_meta_reg;
            echo_prev_reg <= echo_sync_reg;
        end
    end

    assign echo_rise = echo_sync_reg & ~echo_prev_reg;
    assign echo_fall = ~echo_sync_reg & echo_prev_reg;

    // Period expires on its last tick, or was already reached while busy.
    assign period_hit = (period_reg == PERIOD_FULL) || (tick && (period_reg == PERIOD_PRE));

    // Centimetre accumulation: a tick counts when echo was high in the
    // previous cycle, so the tick of the falling-edge cycle is included.
    always_comb begin
        cm_pre_next   = cm_pre_reg;
        cm_count_next = cm_count_reg;
        if (tick && echo_prev_reg) begin
            if (cm_pre_reg == PS_LAST) begin
                cm_pre_next = '0;
                if (cm_count_reg != NO_ECHO) begin
                    cm_count_next = cm_count_reg + 16'd1;
                end
            end else begin
                cm_pre_next = cm_pre_reg + 1'b1;
            end
        end
    end

    // Measurement sequencer with registered trig/distance/valid/timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            trig         <= 1'b0;
            distance     <= NO_ECHO;
            valid        <= 1'b0;
            timeout      <= 1'b0;
            period_reg   <= '0;
            trig_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            cm_pre_reg   <= '0;
            cm_count_reg <= '0;
        end else begin
            valid <= 1'b0;

            // Period counter runs in every state and parks at full scale
            // if the measurement outlasts the period.
            if (tick && (period_reg != PERIOD_FULL)) begin
                period_reg <= period_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (period_hit) begin
                        state_reg    <= ST_TRIG;
                        trig         <= 1'b1;
                        trig_cnt_reg <= '0;
                        period_reg   <= '0;
                    end
                end

                ST_TRIG: begin
                    if (tick) begin
                        if (trig_cnt_reg == TRIG_LAST) begin
                            trig        <= 1'b0;
                            tmo_cnt_reg <= '0;
                            state_reg   <= ST_WAIT_RISE;
                        end else begin
                            trig_cnt_reg <= trig_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_WAIT_RISE: begin
                    if (echo_rise) begin
                        cm_pre_reg   <= '0;
                        cm_count_reg <= '0;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= ST_MEASURE;
                    end else if (tick) begin
                        if (tmo_cnt_reg == TMO_LAST) begin
                            distance  <= NO_ECHO;
                            timeout   <= 1'b1;
                            valid     <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_MEASURE: begin
                    cm_pre_reg   <= cm_pre_next;
                    cm_count_reg <= cm_count_next;
                    if (echo_fall) begin
                        distance  <= cm_count_next;
                        timeout   <= 1'b0;
                        valid     <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (tick) begin
                        if (tmo_cnt_reg == TMO_LAST) begin
                            distance  <= NO_ECHO;
                            timeout   <= 1'b1;
                            valid     <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    trig      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
